hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32: number of architectural registers tracked.
REQ-002 SHALL have parameter NUM_FWD, default 3: number of forwarding sources, index 0 youngest (execute), NUM_FWD-1 oldest (writeback).
REQ-003 SHALL have parameter CNT_W, default 2: width of each per-register pending-write counter.
REQ-004 SHALL have ports as follows; the design has one clock, and reset is synchronous and active-low:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- id_valid  in  1  decode holds an instruction.
- id_ra1, id_ra2  in  $clog2(NREGS)  source register indices.
- id_use1, id_use2  in  1  source actually read.
- id_regwrite  in  1  instruction writes a register.
- id_dst  in  $clog2(NREGS)  destination index.
- id_ready  out  1  issue permitted; issue = id_valid & id_ready.
- wb_valid  in  1  retiring register write.
- wb_dst  in  $clog2(NREGS)  retiring destination.
- fwd_src  in  NUM_FWD x fwd_src_t  {valid, is_load, dst, data} per source.
- flush  in  1  redirect; kill decode instruction.
- srca_mux, srcb_mux  out  1  use forwarded value.
- srca_forward, srcb_forward  out  64  forwarded value.
- stall  out  1  hold fetch/decode.
- clear  out  1  insert bubble into execute.
- stall_cycles  out  32  saturating count of stalled cycles.

Function
REQ-005 SHALL keep pending[r] (CNT_W bits) per register; register 0 is never tracked and always reads pending = 0.
REQ-006 SHALL increment pending[id_dst] on issue with id_regwrite=1 and id_dst!=0.
REQ-007 SHALL decrement pending[wb_dst] on wb_valid=1 with wb_dst!=0.
REQ-008 SHALL leave the counter unchanged when an increment and a decrement hit the same register in the same cycle.
REQ-009 SHALL deassert id_ready when pending[id_dst] = 2^CNT_W-1 and id_regwrite=1 (saturation stall); it SHALL never wrap.
REQ-010 SHALL treat an operand as hazardous when use=1, index!=0 and pending[index]!=0.
REQ-011 SHALL forward a hazardous operand from the lowest-index source with valid=1 and dst=index; mux=1, forward=data, no stall.
REQ-012 SHALL stall if that lowest matching source has is_load=1 (load-use), or if no source matches.
REQ-013 SHALL drive mux=0 and forward=0 for non-hazardous operands.
REQ-014 SHALL compute id_ready = ~flush & ~(operand stall) & ~(saturation stall), combinationally in the same cycle.
REQ-015 SHALL drive stall = id_valid & ~id_ready & ~flush, and clear = stall | flush.
REQ-016 SHALL NOT issue (no counter increment) when flush=1, regardless of hazards.
REQ-017 SHALL increment stall_cycles on every cycle with stall=1 and saturate at 32'hFFFF_FFFF.
REQ-018 SHALL treat a wb_valid with pending[wb_dst]=0 as a no-op (no underflow).

Reset
REQ-019 SHALL, with reset=0 at a rising clk edge, clear all pending counters and stall_cycles to 0.
REQ-020 SHALL hold id_ready=0, stall=0, clear=0, both mux=0 and both forward=0 while reset=0.
REQ-021 SHALL discard an issue or writeback presented in the same cycle as reset.

Configuration
REQ-022 SHALL, with HAZARD_FORWARD_EN defined, behave per REQ-011/012.
REQ-023 SHALL, without HAZARD_FORWARD_EN, stall on every hazardous operand, tie both mux outputs to 0 and both forward outputs to 0, and ignore fwd_src.

Structure
REQ-024 SHALL take fwd_src_t and the existing hazard_data_out typedef from the shared pipes package; NREGS, NUM_FWD and CNT_W remain module parameters.
REQ-025 SHALL instantiate sub-module hazard_fwd_select once per operand; it performs priority selection across fwd_src and returns {hit, is_load, data}.

Verification
REQ-026 Issue ADD x5 with x5 pending, fwd_src[0]={1,0,5,64'h1234} -> srca_mux=1, srca_forward=64'h1234, id_ready=1, stall=0.
REQ-027 LD x7 in fwd_src[0] with is_load=1 and dependent reads x7 -> stall=1, clear=1 for one cycle; next cycle LD in fwd_src[1] with is_load=0 -> forwarded, id_ready=1, stall_cycles=1.
REQ-028 Issue two writes to x3 (CNT_W=2, max 3) plus a third -> pending[x3]=3; fourth write -> id_ready=0 until wb_valid with wb_dst=3.
REQ-029 Issue writing x9 while wb_valid with wb_dst=9 in the same cycle -> pending[x9] unchanged; x0 source or destination -> never stalls or tracked.
REQ-030 flush=1 during a load-use stall -> id_ready=0, stall=0, clear=1, no increment; reset=0 mid-run -> all counters 0 next cycle.
REQ-031 Rebuild without HAZARD_FORWARD_EN and rerun REQ-026 -> stall=1 until wb_valid retires x5, srca_mux=0 throughout.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline types for the hazard scoreboard: forwarding-source and selector result records.
package hazard_scoreboard_pkg;

  localparam int unsigned FwdDstW = 5;
  localparam int unsigned DataW   = 64;

  typedef struct packed {
    logic               valid;
    logic               is_load;
    logic [FwdDstW-1:0] dst;
    logic [DataW-1:0]   data;
  } fwd_src_t;

  typedef struct packed {
    logic             hit;
    logic             is_load;
    logic [DataW-1:0] data;
  } hazard_data_out_t;

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// Priority selector: returns the lowest-index (youngest) valid forwarding source whose dst matches.
module hazard_fwd_select
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned IDX_W   = 5
) (
  input  logic [IDX_W-1:0]         idx,
  input  fwd_src_t [NUM_FWD-1:0]   fwd_src,
  output hazard_data_out_t         result
);

  // Scan oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    result = '0;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (fwd_src[i].valid && (fwd_src[i].dst == FwdDstW'(idx))) begin
        result.hit     = 1'b1;
        result.is_load = fwd_src[i].is_load;
        result.data    = fwd_src[i].data;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard with per-register pending-write counters and operand forwarding.
// Forwarding is enabled by defining HAZARD_FORWARD_EN; otherwise every hazard stalls.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [$clog2(NREGS)-1:0]   id_ra1,
  input  logic [$clog2(NREGS)-1:0]   id_ra2,
  input  logic                       id_use1,
  input  logic                       id_use2,
  input  logic                       id_regwrite,
  input  logic [$clog2(NREGS)-1:0]   id_dst,
  output logic                       id_ready,
  input  logic                       wb_valid,
  input  logic [$clog2(NREGS)-1:0]   wb_dst,
  input  fwd_src_t [NUM_FWD-1:0]     fwd_src,
  input  logic                       flush,
  output logic                       srca_mux,
  output logic                       srcb_mux,
  output logic [63:0]                srca_forward,
  output logic [63:0]                srcb_forward,
  output logic                       stall,
  output logic                       clear,
  output logic [31:0]                stall_cycles
);

  localparam int unsigned IdxW = $clog2(NREGS);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] pending_q [NREGS];
  logic [CNT_W-1:0] pending_d [NREGS];
  logic [31:0]      stall_cycles_q;

  logic [CNT_W-1:0] pend_ra1, pend_ra2, pend_dst, pend_wb;
  logic haz_a, haz_b, op_stall_a, op_stall_b, sat_stall;
  logic issue, inc, dec;
  hazard_data_out_t fwd_a, fwd_b;

  // x0 is hardwired: never report it as pending.
  assign pend_ra1 = (id_ra1 == '0) ? '0 : pending_q[id_ra1];
  assign pend_ra2 = (id_ra2 == '0) ? '0 : pending_q[id_ra2];
  assign pend_dst = (id_dst == '0) ? '0 : pending_q[id_dst];
  assign pend_wb  = (wb_dst == '0) ? '0 : pending_q[wb_dst];

  assign haz_a = id_use1 && (id_ra1 != '0) && (pend_ra1 != '0);
  assign haz_b = id_use2 && (id_ra2 != '0) && (pend_ra2 != '0);

  hazard_fwd_select #(
    .NUM_FWD(NUM_FWD),
    .IDX_W  (IdxW)
  ) u_fwd_a (
    .idx    (id_ra1),
    .fwd_src(fwd_src),
    .result (fwd_a)
  );

  hazard_fwd_select #(
    .NUM_FWD(NUM_FWD),
    .IDX_W  (IdxW)
  ) u_fwd_b (
    .idx    (id_ra2),
    .fwd_src(fwd_src),
    .result (fwd_b)
  );

`ifdef HAZARD_FORWARD_EN
  // A matching load cannot forward yet: its data is not available until a later stage.
  assign op_stall_a   = haz_a && (!fwd_a.hit || fwd_a.is_load);
  assign op_stall_b   = haz_b && (!fwd_b.hit || fwd_b.is_load);
  assign srca_mux     = reset && haz_a && fwd_a.hit && !fwd_a.is_load;
  assign srcb_mux     = reset && haz_b && fwd_b.hit && !fwd_b.is_load;
  assign srca_forward = srca_mux ? fwd_a.data : '0;
  assign srcb_forward = srcb_mux ? fwd_b.data : '0;
`else
  logic unused_fwd;
  assign unused_fwd   = ^{fwd_a, fwd_b};
  assign op_stall_a   = haz_a;
  assign op_stall_b   = haz_b;
  assign srca_mux     = 1'b0;
  assign srcb_mux     = 1'b0;
  assign srca_forward = '0;
  assign srcb_forward = '0;
`endif

  assign sat_stall = id_regwrite && (pend_dst == CntMax);
  assign id_ready  = reset && !flush && !op_stall_a && !op_stall_b && !sat_stall;
  assign stall     = reset && id_valid && !id_ready && !flush;
  assign clear     = stall || (reset && flush);

  assign issue = id_valid && id_ready;
  assign inc   = issue && id_regwrite && (id_dst != '0);
  assign dec   = wb_valid && (wb_dst != '0) && (pend_wb != '0);

  always_comb begin
    for (int r = 0; r < int'(NREGS); r++) begin
      pending_d[r] = pending_q[r];
    end
    pending_d[0] = '0;
    // Simultaneous issue and retire of the same register cancel out.
    if (inc && !(dec && (wb_dst == id_dst))) begin
      pending_d[id_dst] = pending_q[id_dst] + CNT_W'(1);
    end
    if (dec && !(inc && (wb_dst == id_dst))) begin
      pending_d[wb_dst] = pending_q[wb_dst] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        pending_q[r] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < int'(NREGS); r++) begin
        pending_q[r] <= pending_d[r];
      end
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow HAZARD_FORWARD_EN when defined.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

`ifdef HAZARD_FORWARD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_use1, id_use2, id_regwrite, wb_valid, flush;
  logic [4:0] id_ra1, id_ra2, id_dst, wb_dst;
  logic id_ready, srca_mux, srcb_mux, stall, clear;
  logic [63:0] srca_forward, srcb_forward;
  logic [31:0] stall_cycles;
  fwd_src_t [2:0] fwd_src;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_sc = '0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREGS  (32),
    .NUM_FWD(3),
    .CNT_W  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_ra1      (id_ra1),
    .id_ra2      (id_ra2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .id_regwrite (id_regwrite),
    .id_dst      (id_dst),
    .id_ready    (id_ready),
    .wb_valid    (wb_valid),
    .wb_dst      (wb_dst),
    .fwd_src     (fwd_src),
    .flush       (flush),
    .srca_mux    (srca_mux),
    .srcb_mux    (srcb_mux),
    .srca_forward(srca_forward),
    .srcb_forward(srcb_forward),
    .stall       (stall),
    .clear       (clear),
    .stall_cycles(stall_cycles)
  );

  function automatic fwd_src_t mk(input logic v, input logic ld, input logic [4:0] d,
                                  input logic [63:0] data);
    fwd_src_t f;
    f.valid = v; f.is_load = ld; f.dst = d; f.data = data;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic rdy, input logic stl, input logic clr);
    #1;
    chk({tag, ".id_ready"}, {63'd0, id_ready}, {63'd0, rdy});
    chk({tag, ".stall"},    {63'd0, stall},    {63'd0, stl});
    chk({tag, ".clear"},    {63'd0, clear},    {63'd0, clr});
  endtask

  task automatic idle();
    id_valid = 0; id_use1 = 0; id_use2 = 0; id_regwrite = 0; flush = 0; wb_valid = 0;
    id_ra1 = 0; id_ra2 = 0; id_dst = 0; wb_dst = 0;
    fwd_src = '0;
  endtask

  // Advance one clock; the bench model counts the cycle if a stall was expected.
  task automatic commit(input logic stalled);
    @(posedge clk);
    if (stalled && exp_sc != 32'hFFFF_FFFF) exp_sc++;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with issue, writeback and flush all asserted: everything must be discarded.
    idle();
    reset = 0;
    id_valid = 1; id_regwrite = 1; id_dst = 5; wb_valid = 1; wb_dst = 5; flush = 1;
    id_use1 = 1; id_ra1 = 5; fwd_src[0] = mk(1, 0, 5, 64'h1234);
    @(negedge clk);
    ctl("rst", 0, 0, 0);
    chk("rst.srca_mux", {63'd0, srca_mux}, 64'd0);
    chk("rst.srca_forward", srca_forward, 64'd0);
    commit(0);
    chk("rst.stall_cycles", {32'd0, stall_cycles}, 64'd0);
    idle();
    reset = 1;

    // x5 must not be pending after the discarded issue.
    id_valid = 1; id_use1 = 1; id_ra1 = 5;
    ctl("s1", 1, 0, 0);
    commit(0);

    idle(); id_valid = 1; id_regwrite = 1; id_dst = 5;
    ctl("s2", 1, 0, 0);
    commit(0);

    // ADD reading pending x5 with a matching execute-stage source.
    idle(); id_valid = 1; id_use1 = 1; id_ra1 = 5; fwd_src[0] = mk(1, 0, 5, 64'h1234);
    ctl("fwd_a", FwdEn, !FwdEn, !FwdEn);
    chk("fwd_a.srca_mux", {63'd0, srca_mux}, {63'd0, FwdEn});
    chk("fwd_a.srca_forward", srca_forward, FwdEn ? 64'h1234 : 64'd0);
    commit(!FwdEn);
    wb_valid = 1; wb_dst = 5;
    ctl("fwd_a_wb", FwdEn, !FwdEn, !FwdEn);
    chk("fwd_a_wb.srca_mux", {63'd0, srca_mux}, {63'd0, FwdEn});
    commit(!FwdEn);
    wb_valid = 0; fwd_src = '0;
    ctl("x5_retired", 1, 0, 0);
    chk("x5_retired.srca_mux", {63'd0, srca_mux}, 64'd0);
    chk("x5_retired.stall_cycles", {32'd0, stall_cycles}, {32'd0, exp_sc});
    commit(0);

    // Load-use on x7, then the load moves to the next stage with data available.
    idle(); id_valid = 1; id_regwrite = 1; id_dst = 7;
    ctl("ld7", 1, 0, 0);
    commit(0);
    idle(); id_valid = 1; id_use2 = 1; id_ra2 = 7; fwd_src[0] = mk(1, 1, 7, 64'hAA);
    ctl("ldu", 0, 1, 1);
    chk("ldu.srcb_mux", {63'd0, srcb_mux}, 64'd0);
    chk("ldu.srcb_forward", srcb_forward, 64'd0);
    commit(1);
    fwd_src[0] = '0; fwd_src[1] = mk(1, 0, 7, 64'hBEEF);
    ctl("ldu_next", FwdEn, !FwdEn, !FwdEn);
    chk("ldu_next.srcb_forward", srcb_forward, FwdEn ? 64'hBEEF : 64'd0);
    chk("ldu_next.stall_cycles", {32'd0, stall_cycles}, {32'd0, exp_sc});
    commit(!FwdEn);
    // Non-matching youngest source, matching middle beats matching oldest load.
    fwd_src[0] = mk(1, 0, 6, 64'h66); fwd_src[1] = mk(1, 0, 7, 64'h77);
    fwd_src[2] = mk(1, 1, 7, 64'h99);
    ctl("prio", FwdEn, !FwdEn, !FwdEn);
    chk("prio.srcb_mux", {63'd0, srcb_mux}, {63'd0, FwdEn});
    chk("prio.srcb_forward", srcb_forward, FwdEn ? 64'h77 : 64'd0);
    commit(!FwdEn);
    // Lowest match is a load even though an older source has data.
    fwd_src[0] = '0; fwd_src[1] = mk(1, 1, 7, 64'h11); fwd_src[2] = mk(1, 0, 7, 64'h22);
    ctl("prio_ld", 0, 1, 1);
    chk("prio_ld.srcb_mux", {63'd0, srcb_mux}, 64'd0);
    commit(1);

    // Flush during load-use: no issue, so the x8 write is not tracked.
    idle(); id_valid = 1; id_regwrite = 1; id_dst = 8; id_use2 = 1; id_ra2 = 7;
    fwd_src[0] = mk(1, 1, 7, 64'h5); flush = 1;
    ctl("flush", 0, 0, 1);
    commit(0);
    idle(); id_valid = 1; id_use1 = 1; id_ra1 = 8;
    ctl("flush_noinc", 1, 0, 0);
    commit(0);

    // Retire x7, then retire again on an empty counter; it must not wrap.
    idle(); wb_valid = 1; wb_dst = 7;
    commit(0);
    commit(0);
    idle(); id_valid = 1; id_regwrite = 1; id_dst = 7;
    ctl("x7_rewrite", 1, 0, 0);
    commit(0);
    idle(); id_valid = 1; id_use1 = 1; id_ra1 = 7;
    ctl("no_underflow", 0, 1, 1);
    commit(1);
    idle(); wb_valid = 1; wb_dst = 7;
    commit(0);

    // Saturate x3 at 3 outstanding writes.
    for (int i = 0; i < 3; i++) begin
      idle(); id_valid = 1; id_regwrite = 1; id_dst = 3;
      ctl($sformatf("x3_w%0d", i), 1, 0, 0);
      commit(0);
    end
    ctl("sat", 0, 1, 1);
    commit(1);
    wb_valid = 1; wb_dst = 3;
    ctl("sat_wb", 0, 1, 1);
    commit(1);
    wb_valid = 0;
    ctl("sat_release", 1, 0, 0);
    commit(0);
    for (int i = 0; i < 3; i++) begin
      idle(); wb_valid = 1; wb_dst = 3;
      commit(0);
    end
    idle(); id_valid = 1; id_use1 = 1; id_ra1 = 3; id_use2 = 1; id_ra2 = 3;
    ctl("x3_drained", 1, 0, 0);
    commit(0);

    // Same-cycle issue and retire of x9 leaves one write outstanding.
    idle(); id_valid = 1; id_regwrite = 1; id_dst = 9;
    commit(0);
    wb_valid = 1; wb_dst = 9;
    ctl("x9_same", 1, 0, 0);
    commit(0);
    idle(); id_use1 = 1; id_ra1 = 9;
    ctl("x9_still", 0, 0, 0);
    commit(0);
    idle(); wb_valid = 1; wb_dst = 9;
    commit(0);
    idle(); id_valid = 1; id_use1 = 1; id_ra1 = 9;
    ctl("x9_clear", 1, 0, 0);
    commit(0);

    // x0 is never tracked, even after more writes than the counter holds.
    for (int i = 0; i < 4; i++) begin
      idle(); id_valid = 1; id_regwrite = 1; id_dst = 0; id_use1 = 1; id_ra1 = 0;
      ctl($sformatf("x0_w%0d", i), 1, 0, 0);
      commit(0);
    end

    // Pending register with use bits low is not a hazard.
    idle(); id_valid = 1; id_regwrite = 1; id_dst = 12;
    commit(0);
    idle(); id_valid = 1; id_ra1 = 12; id_ra2 = 12;
    ctl("nouse", 1, 0, 0);
    commit(0);

    // Mid-run reset clears pending counters and the stall counter.
    chk("sc_final", {32'd0, stall_cycles}, {32'd0, exp_sc});
    idle(); reset = 0;
    commit(0);
    reset = 1;
    chk("rst2.stall_cycles", {32'd0, stall_cycles}, 64'd0);
    id_valid = 1; id_use1 = 1; id_ra1 = 12;
    ctl("rst2", 1, 0, 0);
    commit(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
